// File: rtl/axis_pkg.sv
// Shared constants and helpers for the byte serializer.
//   DATA_WIDTH_DEF / LEN_WIDTH_DEF : default beat width and length-counter width
//   KEEP_MAX                       : widest keep mask the helpers accept
//   lsb_index(keep)                : index of the lowest set bit (0 when keep==0)
//   is_onehot(keep)                : exactly one bit set
package axis_pkg;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int LEN_WIDTH_DEF  = 16;
    localparam int KEEP_MAX       = 64;

    // EMPTY: nothing held; SERIALIZE: kept bytes still waiting to leave
    typedef enum logic {
        ST_EMPTY,
        ST_SERIALIZE
    } ser_state_t;

    function automatic int lsb_index(input logic [KEEP_MAX-1:0] keep);
        int idx;
        idx = 0;
        for (int i = KEEP_MAX - 1; i >= 0; i--) begin
            if (keep[i]) idx = i;
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [KEEP_MAX-1:0] keep);
        return (keep != '0) && ((keep & (keep - KEEP_MAX'(1))) == '0);
    endfunction

endpackage

// File: rtl/axis_lsb_select.sv
// Combinational priority encoder: picks the lowest set bit of the remaining
// keep mask and the matching byte of the held beat.
//   rem      in  KEEP_WIDTH  remaining kept-byte mask
//   data     in  DATA_WIDTH  held beat
//   idx      out IDX_W       index of lowest set bit of rem (0 when rem==0)
//   sel_byte out 8           byte at that index
module axis_lsb_select
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    localparam int KEEP_WIDTH = DATA_WIDTH / 8,
    localparam int IDX_W = (KEEP_WIDTH > 1) ? $clog2(KEEP_WIDTH) : 1
) (
    input  logic [KEEP_WIDTH-1:0] rem,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [IDX_W-1:0]      idx,
    output logic [7:0]            sel_byte
);

    logic [KEEP_WIDTH-1:0][7:0] lanes;

    assign lanes    = data;
    assign idx      = IDX_W'(lsb_index(KEEP_MAX'(rem)));
    assign sel_byte = lanes[idx];

endmodule

// File: rtl/axis_byte_serializer.sv
// Breaks DATA_WIDTH-bit AXI-Stream beats into single bytes, dropping null
// (tkeep-clear) bytes, and reports each packet's byte count.
//   aclk, areset         clock, synchronous active-high reset
//   s_axis_*             input beats (tvalid/tready/tdata/tkeep/tlast)
//   m_axis_*             output bytes (tvalid/tready/tdata/tlast)
//   pkt_len/pkt_len_valid  byte count of the packet just closed, one-cycle pulse
//   err_null_last        one-cycle pulse: accepted beat had tlast=1, tkeep=0
module axis_byte_serializer
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
    localparam int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic [LEN_WIDTH-1:0]  pkt_len,
    output logic                  pkt_len_valid,
    output logic                  err_null_last
);

    localparam int IDX_W = (KEEP_WIDTH > 1) ? $clog2(KEEP_WIDTH) : 1;

    ser_state_t            state;
    logic [KEEP_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [LEN_WIDTH-1:0]  pkt_len_d;
    logic                  plv_d, err_d;
    logic                  one_left, xfer, accept;
    logic [IDX_W-1:0]      sel_idx;
    logic [7:0]            sel_byte;

    axis_lsb_select #(.DATA_WIDTH(DATA_WIDTH)) u_sel (
        .rem      (rem_q),
        .data     (data_q),
        .idx      (sel_idx),
        .sel_byte (sel_byte)
    );

    always_comb begin
        state     = (rem_q == '0) ? ST_EMPTY : ST_SERIALIZE;
        one_left  = is_onehot(KEEP_MAX'(rem_q));

        m_axis_tvalid = (state == ST_SERIALIZE);
        m_axis_tdata  = m_axis_tvalid ? sel_byte : 8'h00;
        m_axis_tlast  = last_q && one_left;
        xfer          = m_axis_tvalid && m_axis_tready;
        // Ready also while the final held byte leaves, so beats stream with no bubble.
        s_axis_tready = !areset && ((state == ST_EMPTY) || (xfer && one_left));
        accept        = s_axis_tvalid && s_axis_tready;

        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + LEN_WIDTH'(1);

        rem_d     = rem_q;
        data_d    = data_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        pkt_len_d = pkt_len;
        plv_d     = 1'b0;
        err_d     = 1'b0;

        if (xfer) begin
            rem_d = rem_q & ~(KEEP_WIDTH'(1) << sel_idx);
            cnt_d = cnt_inc;
            if (m_axis_tlast) begin
                pkt_len_d = cnt_inc;
                plv_d     = 1'b1;
                cnt_d     = '0;
            end
        end

        if (accept) begin
            rem_d  = s_axis_tkeep;
            data_d = s_axis_tdata;
            last_d = s_axis_tlast;
            if ((s_axis_tkeep == '0) && s_axis_tlast) begin
                err_d = 1'b1;
                // If a real tlast byte closes a packet on this same edge, the
                // null-last packet is empty and its zero length is not reported.
                if (!plv_d) begin
                    pkt_len_d = cnt_d;
                    plv_d     = 1'b1;
                end
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rem_q         <= '0;
            data_q        <= '0;
            last_q        <= 1'b0;
            cnt_q         <= '0;
            pkt_len       <= '0;
            pkt_len_valid <= 1'b0;
            err_null_last <= 1'b0;
        end else begin
            rem_q         <= rem_d;
            data_q        <= data_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            pkt_len       <= pkt_len_d;
            pkt_len_valid <= plv_d;
            err_null_last <= err_d;
        end
    end

endmodule

// File: tb/tb_axis_byte_serializer.sv
module tb_axis_byte_serializer;

    logic        aclk = 1'b0;
    logic        areset;
    logic        s_tvalid, s_tlast, m_tready;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tready, m_tvalid, m_tlast, plv, err;
    logic [7:0]  m_tdata;
    logic [15:0] pkt_len;
    // LEN_WIDTH=4 build fed with the same stimulus
    logic        s_tready4, m_tvalid4, m_tlast4, plv4, err4;
    logic [7:0]  m_tdata4;
    logic [3:0]  pkt_len4;

    always #5 aclk = ~aclk;

    axis_byte_serializer dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
        .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
        .m_axis_tlast(m_tlast), .pkt_len(pkt_len), .pkt_len_valid(plv), .err_null_last(err)
    );

    axis_byte_serializer #(.LEN_WIDTH(4)) dut4 (
        .aclk(aclk), .areset(areset),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready4), .s_axis_tdata(s_tdata),
        .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid4), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata4),
        .m_axis_tlast(m_tlast4), .pkt_len(pkt_len4), .pkt_len_valid(plv4), .err_null_last(err4)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [8:0] exp_q[$];     // {last, byte}
    int         len_q[$];
    int         n_err_exp = 0;
    int         m_bytes = 0;
    logic [7:0] got_q[$];
    int         cyc = 0, nxfer = 0, n_plv = 0, n_err_seen = 0, n_acc = 0;
    int         span_first = -1, span_last = -1;
    int         last_len = -1, last_len4 = -1;
    logic       stall = 1'b0;
    logic [8:0] stall_val;
    int         ready_mode = 1;

    function automatic void model_accept(input logic [63:0] d, input logic [7:0] k, input logic l);
        for (int i = 0; i < 8; i++) begin
            if (k[i]) begin
                exp_q.push_back({1'b0, d[8*i +: 8]});
                m_bytes++;
            end
        end
        if (l) begin
            if (k != 0) exp_q[exp_q.size()-1][8] = 1'b1;
            else        n_err_exp++;
            len_q.push_back(m_bytes);
            m_bytes = 0;
        end
    endfunction

    always @(negedge aclk) begin
        cyc++;
        if (areset) begin
            exp_q.delete();
            len_q.delete();
            m_bytes = 0;
            stall   = 1'b0;
        end else begin
            if (m_tvalid && stall) chk("stall_hold", {m_tlast, m_tdata}, stall_val);
            if (m_tvalid && m_tready) begin
                nxfer++;
                got_q.push_back(m_tdata);
                if (span_first < 0) span_first = cyc;
                span_last = cyc;
                chk("byte_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("m_tdata", m_tdata, e[7:0]);
                    chk("m_tlast", m_tlast, e[8]);
                end
            end
            stall     = m_tvalid && !m_tready;
            stall_val = {m_tlast, m_tdata};
            if (s_tvalid && s_tready) begin
                n_acc++;
                model_accept(s_tdata, s_tkeep, s_tlast);
            end
            if (plv) begin
                n_plv++;
                last_len  = pkt_len;
                last_len4 = pkt_len4;
                chk("len_expected", len_q.size() != 0, 1);
                if (len_q.size() != 0) begin
                    int l;
                    l = len_q.pop_front();
                    chk("pkt_len", pkt_len, l);
                    chk("pkt_len_sat4", pkt_len4, (l > 15) ? 15 : l);
                    chk("plv4", plv4, 1);
                end
            end
            if (err) begin
                n_err_seen++;
                chk("err_expected", n_err_exp > 0, 1);
                if (n_err_exp > 0) n_err_exp--;
            end
        end
    end

    always @(posedge aclk) begin
        #1;
        m_tready = (ready_mode != 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    // ---------------- stimulus helpers ----------------
    // Callers enter and leave these tasks 1 time unit after a rising edge.
    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
        while (!acc && n < 200) begin
            @(negedge aclk);
            acc = s_tready;
            @(posedge aclk);
            n++;
        end
        #1;
        s_tvalid = 1'b0;
        chk("beat_accepted", acc, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_tvalid) && n < 2000) begin
            @(negedge aclk);
            n++;
        end
        repeat (3) @(negedge aclk);
        chk("drain_bytes_left", exp_q.size(), 0);
        chk("drain_len_left", len_q.size(), 0);
        chk("drain_err_left", n_err_exp, 0);
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_pkt_len", pkt_len, 0);
        chk("rst_plv", plv, 0);
        chk("rst_err", err, 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        chk("post_rst_s_tready", s_tready, 1);
        @(posedge aclk);
        #1;
    endtask

    task automatic four_beats();
        send_beat({8{8'h11}}, 8'hFF, 1'b0);
        send_beat({8{8'h22}}, 8'hFF, 1'b0);
        send_beat({8{8'h33}}, 8'hFF, 1'b0);
        send_beat({8{8'h44}}, 8'hFF, 1'b1);
    endtask

    initial begin
        logic [7:0] t1_exp[6];
        logic [7:0] seq2[$];
        int b_xfer, b_acc, b_plv, b_err, gen_bytes;

        s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; m_tready = 1'b1;
        do_reset();

        // T1: sparse keep, single packet
        t1_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h77, 8'h88};
        got_q.delete();
        send_beat(64'h8877665544332211, 8'hCF, 1'b1);
        drain();
        chk("t1_nbytes", got_q.size(), 6);
        for (int i = 0; i < 6 && i < got_q.size(); i++) chk("t1_byte", got_q[i], t1_exp[i]);
        chk("t1_len", last_len, 6);

        // T2: four full beats, no backpressure, no bubbles
        got_q.delete();
        span_first = -1;
        b_acc = n_acc;
        four_beats();
        drain();
        chk("t2_nbytes", got_q.size(), 32);
        chk("t2_span", span_last - span_first, 31);
        chk("t2_beats", n_acc - b_acc, 4);
        chk("t2_len", last_len, 32);
        chk("t2_len_sat4", last_len4, 15);
        seq2 = got_q;

        // T3: same stimulus with random backpressure
        ready_mode = 0;
        got_q.delete();
        four_beats();
        drain();
        chk("t3_nbytes", got_q.size(), 32);
        for (int i = 0; i < 32 && i < got_q.size(); i++) chk("t3_same_seq", got_q[i], seq2[i]);
        chk("t3_len", last_len, 32);

        // T4: null beats inside a packet, then a null tlast
        ready_mode = 1;
        b_err = n_err_seen;
        got_q.delete();
        send_beat({8{8'h5A}}, 8'hFF, 1'b0);
        send_beat({8{8'hEE}}, 8'h00, 1'b0);
        send_beat({8{8'hA5}}, 8'hFF, 1'b0);
        send_beat({8{8'hEE}}, 8'h00, 1'b1);
        drain();
        chk("t4_nbytes", got_q.size(), 16);
        chk("t4_err_pulses", n_err_seen - b_err, 1);
        chk("t4_len", last_len, 16);

        // T5: reset after 3 of 8 bytes
        b_xfer = nxfer;
        b_plv  = n_plv;
        send_beat(64'hF8F7F6F5F4F3F2F1, 8'hFF, 1'b1);
        repeat (3) @(posedge aclk);
        #1;
        do_reset();
        chk("t5_bytes_before_rst", nxfer - b_xfer, 3);
        repeat (4) @(posedge aclk);
        #1;
        chk("t5_no_plv", n_plv - b_plv, 0);

        // T6: next packet counts from zero
        send_beat(64'h0807060504030201, 8'hFF, 1'b1);
        drain();
        chk("t6_len", last_len, 8);

        // Random beats against the model, random backpressure
        ready_mode = 0;
        gen_bytes = 0;
        for (int i = 0; i < 60; i++) begin
            logic [63:0] d;
            logic [7:0]  k;
            logic        l;
            d = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0:       k = 8'h00;
                1:       k = 8'hCF;
                2:       k = 8'hFF;
                default: k = 8'($urandom);
            endcase
            l = ($urandom_range(0, 3) == 0);
            // an empty null-last packet is not exercised
            if (k == 0 && l && gen_bytes == 0) l = 1'b0;
            gen_bytes = l ? 0 : gen_bytes + $countones(k);
            send_beat(d, k, l);
        end
        send_beat(64'h0, 8'h01, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
